// File: rtl/car_park_controller_if.sv
// Sensor inputs and occupancy/status outputs of the car park controller.
// master: sensor front end / monitor side; slave: the controller itself.
interface car_park_controller_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en_a;
  logic             en_b;
  logic             ex_a;
  logic             ex_b;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] car_count;
  logic             full;
  logic             empty;
  logic             entry_gate;
  logic             error;

  modport master (
    output en_a, en_b, ex_a, ex_b,
    input  inc, dec, car_count, full, empty, entry_gate, error
  );

  modport slave (
    input  en_a, en_b, ex_a, ex_b,
    output inc, dec, car_count, full, empty, entry_gate, error
  );
endinterface

// File: rtl/car_park_controller.sv
// Car park occupancy controller: two beam-pair lane FSMs recognise forward
// passages, a round-robin arbiter turns them into inc/dec pulses on a
// saturating occupancy counter, and status/gate outputs follow the count.
module car_park_controller #(
  parameter int unsigned CAPACITY = 15,
  parameter int unsigned WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  car_park_controller_if.slave bus
);

  // Lane state encoding matches the {a,b} sensor sample it represents.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S_A  = 2'b10,
    S_AB = 2'b11,
    S_B  = 2'b01
  } lane_t;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } grant_t;

  typedef struct packed {
    lane_t nxt;
    logic  done;
    logic  bad;
  } step_t;

  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

  lane_t            en_q, ex_q;
  logic             pend_en_q, pend_ex_q;
  grant_t           last_q;
  logic [WIDTH-1:0] count_q;
  logic             inc_q, dec_q, err_q;

  step_t            st_en, st_ex;
  logic             grant_en, grant_ex;
  logic             pend_en_d, pend_ex_d;
  grant_t           last_d;
  logic [WIDTH-1:0] count_d;
  logic             inc_d, dec_d, err_d;

  // One lane step: single-step moves along IDLE-S_A-S_AB-S_B are legal,
  // S_B->IDLE completes a passage, anything else forces IDLE with an error.
  function automatic step_t lane_step(lane_t cur, logic [1:0] s);
    step_t r;
    r.nxt  = cur;
    r.done = 1'b0;
    r.bad  = 1'b0;
    unique case (cur)
      IDLE: begin
        if (s == 2'b10)      r.nxt = S_A;
        else if (s != 2'b00) r.bad = 1'b1;
      end
      S_A: begin
        if (s == 2'b11)      r.nxt = S_AB;
        else if (s == 2'b00) r.nxt = IDLE;
        else if (s == 2'b01) r.bad = 1'b1;
      end
      S_AB: begin
        if (s == 2'b01)      r.nxt = S_B;
        else if (s == 2'b10) r.nxt = S_A;
        else if (s == 2'b00) r.bad = 1'b1;
      end
      S_B: begin
        if (s == 2'b00) begin
          r.nxt  = IDLE;
          r.done = 1'b1;
        end
        else if (s == 2'b11) r.nxt = S_AB;
        else if (s == 2'b10) r.bad = 1'b1;
      end
      default: r.bad = 1'b1;
    endcase
    if (r.bad) r.nxt = IDLE;
    return r;
  endfunction

  // State, pending flags, arbiter history, counter and output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= IDLE;
      ex_q      <= IDLE;
      pend_en_q <= 1'b0;
      pend_ex_q <= 1'b0;
      last_q    <= ENTRY;
      count_q   <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_q      <= st_en.nxt;
      ex_q      <= st_ex.nxt;
      pend_en_q <= pend_en_d;
      pend_ex_q <= pend_ex_d;
      last_q    <= last_d;
      count_q   <= count_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
    end
  end

  // Lane steps, round-robin grant and saturating count update.
  always_comb begin
    st_en    = lane_step(en_q, {bus.en_a, bus.en_b});
    st_ex    = lane_step(ex_q, {bus.ex_a, bus.ex_b});
    grant_en = pend_en_q && (!pend_ex_q || last_q == EXIT);
    grant_ex = pend_ex_q && (!pend_en_q || last_q == ENTRY);
    count_d  = count_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    err_d    = st_en.bad | st_ex.bad;
    last_d   = last_q;
    if (grant_en) begin
      last_d = ENTRY;
      if (count_q < CAP) begin
        count_d = count_q + WIDTH'(1);
        inc_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (grant_ex) begin
      last_d = EXIT;
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
        dec_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // A lane cannot complete again before its flag is granted, so set wins.
    pend_en_d = (pend_en_q && !grant_en) || st_en.done;
    pend_ex_d = (pend_ex_q && !grant_ex) || st_ex.done;
  end

  assign bus.inc        = inc_q;
  assign bus.dec        = dec_q;
  assign bus.error      = err_q;
  assign bus.car_count  = count_q;
  assign bus.full       = (count_q == CAP);
  assign bus.empty      = (count_q == '0);
  assign bus.entry_gate = (count_q != CAP);

endmodule

// File: doc/car_park_controller.md
Name: car_park_controller

Overview:
- Sequences the parking-lot occupancy counter from two independent sensor lanes (entry, exit).
- Each lane has a two-beam sensor pair (a, b). A lane FSM recognises one complete, forward vehicle passage.
- A round-robin arbiter serialises entry and exit events into single-cycle inc/dec pulses and maintains the occupancy count.
- Drives the entry gate and full/empty status, and sits between the sensor front end and the car-count display/monitor path.

Parameters:
- CAPACITY, 15, maximum occupancy; legal range 1..15.
- WIDTH, 4, width of car_count; must hold CAPACITY.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- en_a  input  1  entry lane outer beam blocked (1 = blocked).
- en_b  input  1  entry lane inner beam blocked.
- ex_a  input  1  exit lane inner beam blocked.
- ex_b  input  1  exit lane outer beam blocked.
- inc  output  1  one-cycle pulse: occupancy incremented this cycle.
- dec  output  1  one-cycle pulse: occupancy decremented this cycle.
- car_count  output  WIDTH  current occupancy.
- full  output  1  car_count == CAPACITY, combinational from car_count.
- empty  output  1  car_count == 0, combinational from car_count.
- entry_gate  output  1  1 = gate open, equal to !full.
- error  output  1  one-cycle pulse on an illegal sensor sequence, overflow or underflow.

Behaviour:
- Reset (rst=0): both lane FSMs IDLE, both pending flags 0, last_grant = ENTRY, car_count=0, inc=dec=error=0. Therefore empty=1, full=0, entry_gate=1. Reset mid-passage or mid-arbitration discards all in-flight events.
- Sensors are sampled directly on each rising clk edge; inputs are synchronous.
- Lane FSM (identical for both lanes), encoded on {a,b}: IDLE(00), S_A(10), S_AB(11), S_B(01).
  - Forward path: IDLE->S_A->S_AB->S_B->IDLE. The S_B->IDLE step (sample 00) is a completion and sets that lane's pending flag.
  - Backward steps along the same chain (S_AB->S_A, S_A->IDLE, S_B->S_AB) are legal. They produce no event (car reversed).
  - Unchanged sample: stay in the current state.
  - Any sample two steps away (IDLE<->S_AB, S_A<->S_B): error pulse next cycle, FSM forced to IDLE, no event.
  - From IDLE, sample 01 (passage started from the wrong side): treated as illegal, same handling.
- Arbiter, evaluated every cycle on the pending flags:
  - One pending: grant it.
  - Both pending: grant the lane not in last_grant, then update last_grant.
  - Granted pending flag clears on the same edge. The loser is granted the next cycle, so its maximum wait is 1 cycle. A lane needs ≥4 cycles per passage, so no event is lost.
- Grant ENTRY: if car_count<CAPACITY, car_count+1 and inc=1. Otherwise (overflow) car_count unchanged, inc=0, error=1.
- Grant EXIT: if car_count>0, car_count-1 and dec=1. Otherwise (underflow) car_count unchanged, dec=0, error=1.
- inc, dec and error are registered and high for exactly one cycle. inc and dec are never both 1.
- Latency: completion sampled at edge N sets pending. The grant at edge N+1 updates car_count and raises inc/dec together (2 edges from the final 00 sample).
- No wrap-around ever; count saturates at 0 and CAPACITY.
- full/empty/entry_gate follow car_count the same cycle.

Test Plan:
- Reset, then entry lane driven 00,10,11,01,00 (one value per cycle) -> inc pulses once, 2 edges after the final 00; car_count=1; empty falls to 0.
- Entry lane 00,10,11,10,00 (car reverses) -> no inc, no error, car_count unchanged.
- car_count=5; entry and exit passages complete on the same edge -> exit granted first (dec, count 4), then entry next cycle (inc, count 5); last_grant=ENTRY.
- 15 entry passages from reset -> car_count=15, full=1, entry_gate=0. A 16th passage -> inc=0, error=1, count stays 15.
- Exit passage at car_count=0 -> dec=0, error=1, count 0. Entry lane jump 00->11 -> error one cycle later, FSM in IDLE.
- Assert rst=0 asynchronously while the entry FSM is in S_AB and a pending exit exists at car_count=7 -> outputs clear immediately (count 0, inc=dec=0). After release, the next full passage increments normally.
